mem_fifo_ctrl: RTL

- Upstream controller that turns the 16x5 single-port register-file memory into a first-in-first-out queue with valid/ready handshakes on both sides.
- Drives the memory's write_enable, address and data_in pins and consumes its combinational data_out.
- Adds one output holding register, so the queue holds DEPTH+1 words.
- Arbitrates the single memory port between pushes and head prefetches.

---
 rtl/mem_fifo_ctrl_pkg.sv | 14 +
 rtl/mem_fifo_ctrl_wrap_ptr.sv | 38 +++
 rtl/mem_fifo_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_fifo_ctrl_pkg.sv
// Shared constants and the arbitration grant encoding for the memory-backed FIFO controller.
package mem_fifo_pkg;

    localparam int DW    = 5;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    // Which side of the single memory port was served most recently.
    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

endpackage : mem_fifo_pkg

// File: rtl/mem_fifo_ctrl_wrap_ptr.sv
// Circular address pointer: advances by one when inc is high, wraps DEPTH-1 -> 0.
module wrap_ptr #(
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // Next pointer value, wrapping explicitly so DEPTH need not be a power of two here.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            if (ptr_q == AW'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule : wrap_ptr

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller wrapped around a single-port register-file memory with a
// combinational read port. One output holding register extends capacity to
// DEPTH+1 words. Pushes and head prefetches share the memory port through a
// two-state round-robin arbiter.
// Optional build macro MEM_FIFO_BYPASS_EN: when the whole FIFO is empty (or the
// head is being taken) an incoming word is loaded straight into the output
// register, skipping the memory and cutting push-to-valid latency to one cycle.
module mem_fifo_ctrl
    import mem_fifo_pkg::*;
#(
    parameter int DW    = mem_fifo_pkg::DW,
    parameter int AW    = mem_fifo_pkg::AW,
    parameter int DEPTH = mem_fifo_pkg::DEPTH
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic [AW:0]   mem_cnt_q;
    logic [AW:0]   mem_cnt_d;
    logic          out_valid_q;
    logic          out_valid_d;
    logic [DW-1:0] out_data_q;
    logic [DW-1:0] out_data_d;
    grant_t        last_grant_q;
    grant_t        last_grant_d;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic wr_req;
    logic rd_req;
    logic grant_wr;
    logic grant_rd;
    logic bypass;
    logic mem_full;
    logic mem_empty;
    logic head_free;

    assign mem_full  = (mem_cnt_q == (AW + 1)'(DEPTH));
    assign mem_empty = (mem_cnt_q == '0);
    assign head_free = !out_valid_q || out_ready;

    assign wr_req = in_valid && !mem_full;
    assign rd_req = !mem_empty && head_free;

`ifdef MEM_FIFO_BYPASS_EN
    // Only possible with an empty memory, so it never competes with a prefetch.
    assign bypass = in_valid && mem_empty && head_free;
`else
    assign bypass = 1'b0;
`endif

    // Round-robin: a lone request wins; on contention the side not served last wins.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!bypass) begin
            if (wr_req && rd_req) begin
                grant_wr = (last_grant_q == GRANT_RD);
                grant_rd = (last_grant_q == GRANT_WR);
            end else begin
                grant_wr = wr_req;
                grant_rd = rd_req;
            end
        end
    end

    // Memory port and upstream handshake; suppressed while reset is held so an
    // in-flight write is abandoned immediately.
    always_comb begin
        in_ready  = !reset && (grant_wr || bypass);
        mem_we    = !reset && grant_wr;
        mem_addr  = grant_wr ? wr_ptr : rd_ptr;
        mem_wdata = in_data;
    end

    // Next-state for occupancy, output holding register and arbiter history.
    always_comb begin
        mem_cnt_d    = mem_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        last_grant_d = last_grant_q;

        if (grant_wr) begin
            mem_cnt_d    = mem_cnt_q + 1'b1;
            last_grant_d = GRANT_WR;
        end else if (grant_rd) begin
            mem_cnt_d    = mem_cnt_q - 1'b1;
            last_grant_d = GRANT_RD;
        end

        if (grant_rd) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_rdata;
        end else if (bypass) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers, including the two-state arbiter FSM.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            mem_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            last_grant_q <= GRANT_RD;
        end else begin
            mem_cnt_q    <= mem_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    wrap_ptr #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .Clk   (Clk),
        .reset (reset),
        .inc   (grant_wr),
        .ptr   (wr_ptr)
    );

    wrap_ptr #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .Clk   (Clk),
        .reset (reset),
        .inc   (grant_rd),
        .ptr   (rd_ptr)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = mem_cnt_q + {{AW{1'b0}}, out_valid_q};
    assign full      = mem_full;
    assign empty     = !out_valid_q && mem_empty;

endmodule : mem_fifo_ctrl
